// File: rtl/toggle_pkg.sv
// Shared mode encodings and helpers for the toggle flop bank.
package toggle_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_SET    = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic [31:0] max);
    return (count == max) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_edge_detect.sv
// Per-bit strobe qualifier: passes t_in straight through (level) or
// reduces it to 0->1 transitions against the previous cycle (edge).
module toggle_edge_detect #(
  parameter int WIDTH     = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t_in,
  output logic [WIDTH-1:0] t_eff
);

  logic [WIDTH-1:0] t_prev;

  // t_prev tracks t_in regardless of en/mode, so edges seen while the
  // bank is disabled are consumed rather than replayed later.
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) t_prev <= '0;
    else        t_prev <= t_in;
  end

  assign t_eff = (EDGE_MODE != 0) ? (t_in & ~t_prev) : t_in;

endmodule

// File: rtl/toggle_ff_bank.sv
// WIDTH-channel T-flop bank with toggle/load/set/clear modes, per-bit
// change pulses and a saturating count of cycles in which anything changed.
module toggle_ff_bank
  import toggle_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 8,
  parameter int               EDGE_MODE = 0,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] tog_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] t_eff;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] diff;

  toggle_edge_detect #(
    .WIDTH    (WIDTH),
    .EDGE_MODE(EDGE_MODE)
  ) u_edge (
    .clk  (clk),
    .reset(reset),
    .t_in (t_in),
    .t_eff(t_eff)
  );

  // NOTE: q_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_TOGGLE: q_next = q ^ t_eff;
        MODE_LOAD:   q_next = d_in;
        MODE_SET:    q_next = q | t_eff;
        MODE_CLEAR:  q_next = q & ~t_eff;
        default:     q_next = q;
      endcase
    end
  end

  assign diff = q_next ^ q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= INIT;
      changed   <= '0;
      tog_count <= '0;
    end else begin
      q       <= q_next;
      changed <= diff;
      // A clear wins over a coincident change; that change goes uncounted.
      if (cnt_clr)
        tog_count <= '0;
      else if (|diff)
        tog_count <= CNT_W'(sat_inc(32'(tog_count), 32'(CNT_MAX)));
    end
  end

endmodule

// File: tb/tb_toggle_ff_bank.sv
// Scoreboard bench: three bank instances (level/INIT, edge, narrow counter)
// share stimulus; each step queues the expected response of one instance.
module tb_toggle_ff_bank;
  import toggle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_in;
  logic [3:0] d_in;
  logic       cnt_clr;

  logic [3:0] q0, ch0, q1, ch1, q2, ch2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         dut;
    logic [3:0] q;
    logic [3:0] ch;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  toggle_ff_bank #(.WIDTH(4), .CNT_W(8), .EDGE_MODE(0), .INIT(4'b1010)) u0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_in(t_in), .d_in(d_in),
    .cnt_clr(cnt_clr), .q(q0), .changed(ch0), .tog_count(cnt0));

  toggle_ff_bank #(.WIDTH(4), .CNT_W(8), .EDGE_MODE(1), .INIT(4'b0000)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_in(t_in), .d_in(d_in),
    .cnt_clr(cnt_clr), .q(q1), .changed(ch1), .tog_count(cnt1));

  toggle_ff_bank #(.WIDTH(4), .CNT_W(2), .EDGE_MODE(0), .INIT(4'b0000)) u2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t_in(t_in), .d_in(d_in),
    .cnt_clr(cnt_clr), .q(q2), .changed(ch2), .tog_count(cnt2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the
  // selected instance must show after the following rising edge.
  task automatic step(input int dut, input logic e, input logic [1:0] m,
                      input logic [3:0] t, input logic [3:0] d, input logic clr,
                      input logic [3:0] eq, input logic [3:0] ech,
                      input logic [7:0] ecnt, input string name);
    exp_t x;
    @(negedge clk);
    en = e; mode = m; t_in = t; d_in = d; cnt_clr = clr;
    x.dut = dut; x.q = eq; x.ch = ech; x.cnt = ecnt; x.name = name;
    sb.push_back(x);
  endtask

  task automatic idle_inputs();
    en = 1'b0; mode = MODE_TOGGLE; t_in = '0; d_in = '0; cnt_clr = 1'b0;
  endtask

  // Monitor: compare one queued expectation per cycle, just after the edge.
  always @(posedge clk) begin
    exp_t x;
    logic [3:0] aq, ach;
    logic [7:0] acnt;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.dut)
        0:       begin aq = q0; ach = ch0; acnt = cnt0; end
        1:       begin aq = q1; ach = ch1; acnt = cnt1; end
        default: begin aq = q2; ach = ch2; acnt = {6'b0, cnt2}; end
      endcase
      check({x.name, ".q"},       32'(aq),   32'(x.q));
      check({x.name, ".changed"}, 32'(ach),  32'(x.ch));
      check({x.name, ".count"},   32'(acnt), 32'(x.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset.u0.q",     32'(q0),   32'h a);
    check("reset.u0.chg",   32'(ch0),  32'h0);
    check("reset.u0.count", 32'(cnt0), 32'h0);
    check("reset.u1.q",     32'(q1),   32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Level toggle on the narrow-counter bank from 0000.
    step(2, 1, MODE_TOGGLE, 4'b0011, 4'b0000, 0, 4'b0011, 4'b0011, 8'd1, "lvl1");
    step(2, 1, MODE_TOGGLE, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0011, 8'd2, "lvl2");
    step(2, 1, MODE_TOGGLE, 4'b0011, 4'b0000, 0, 4'b0011, 4'b0011, 8'd3, "lvl3");

    // Asynchronous reset mid-run: u0 has moved to 1001 with count 3.
    @(posedge clk);
    #3;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("async.u0.q",     32'(q0),   32'h a);
    check("async.u0.chg",   32'(ch0),  32'h0);
    check("async.u0.count", 32'(cnt0), 32'h0);
    check("async.u2.count", 32'(cnt2), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Edge-qualified toggling.
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 8'd1, "edg1");
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 8'd1, "edg2");
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 8'd1, "edg3");
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 8'd1, "edg4");
    step(1, 1, MODE_TOGGLE, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 8'd1, "edg_low");
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd2, "edg_rise");
    step(1, 1, MODE_TOGGLE, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 8'd2, "edg_low2");
    step(1, 0, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 8'd2, "edg_dis");
    step(1, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 8'd2, "edg_reen");

    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Set / clear / load, hold, then counter saturation and clear.
    step(2, 1, MODE_SET,    4'b0101, 4'b0000, 0, 4'b0101, 4'b0101, 8'd1, "set1");
    step(2, 1, MODE_SET,    4'b0100, 4'b0000, 0, 4'b0101, 4'b0000, 8'd1, "set_same");
    step(2, 1, MODE_CLEAR,  4'b0001, 4'b0000, 0, 4'b0100, 4'b0001, 8'd2, "clr1");
    step(2, 1, MODE_LOAD,   4'b0000, 4'b1111, 0, 4'b1111, 4'b1011, 8'd3, "load1");
    step(2, 1, MODE_LOAD,   4'b1010, 4'b0000, 1, 4'b0000, 4'b1111, 8'd0, "load0_clr");
    step(2, 0, MODE_LOAD,   4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 8'd0, "hold");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 8'd1, "sat1");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd2, "sat2");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 8'd3, "sat3");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0001, 8'd3, "sat4");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 8'd3, "sat5");
    step(2, 1, MODE_TOGGLE, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0001, 8'd0, "clr_tog");

    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard.drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
